lsu_handshake: RTL and testbench

Parametrised load/store unit for the next-generation pipelined core. It replaces the fixed single-cycle data-memory port with a valid/grant/rvalid handshake, so data memory may have variable latency. The block sits between the MEM stage and data memory. It generates byte enables, lane-aligns write data and sign/zero-extends read data. It stalls the pipeline while a transfer is outstanding and reports misalignment, illegal size and timeout errors.

---
 rtl/lsu_handshake.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_lsu_handshake.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_handshake.sv
// ---------------------------------------------------------------------------
// lsu_handshake
//
// Load/store unit between the MEM stage and a variable-latency data memory.
// A request seen in IDLE is decoded and captured, then issued on a
// valid/grant/rvalid handshake. The pipeline is stalled while the transfer is
// outstanding. Byte enables and lane-replicated store data are generated at
// capture time. Load data is lane-selected and sign/zero-extended when it
// returns. Misaligned accesses, illegal size codes and handshake timeouts are
// reported as a one-cycle error pulse.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid/we/funct3/     MEM-stage request; the fields are held stable
//   addr/wdata/rd            while stall=1
//   stall                    freeze the front of the pipeline
//   resp_valid/rdata/rd      one-cycle completion (rd forced to 0 for stores)
//   err_valid/err_code       one-cycle error (01 misaligned, 10 timeout,
//                            11 illegal funct3)
//   mem_req/we/addr/be/wdata memory request (addr is word-aligned)
//   mem_gnt                  memory accepted the request
//   mem_rvalid/mem_rdata     read data valid or write acknowledge
// ---------------------------------------------------------------------------
module lsu_handshake #(
    parameter int WIDTH   = 32,
    parameter int DADDR   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [DADDR-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [4:0]         req_rd,
    output logic               stall,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic [4:0]         resp_rd,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DADDR-1:0]   mem_addr,
    output logic [WIDTH/8-1:0] mem_be,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam int NB = WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(TIMEOUT);

    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [OW-1:0]      off_q, off_d;
    logic [4:0]         rd_q, rd_d;
    logic [DADDR-1:0]   addr_q, addr_d;
    logic [NB-1:0]      be_q, be_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]         code_q, code_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Request decode (live request fields, used only when captured)
    // ------------------------------------------------------------------
    logic [1:0]       req_size;
    logic             req_uns;
    logic             req_legal;
    logic             req_misal;
    logic [OW-1:0]    req_off;
    logic [NB-1:0]    size_mask;
    logic [NB-1:0]    req_be;
    logic [WIDTH-1:0] req_wlane;

    assign req_size = req_funct3[1:0];
    assign req_uns  = req_funct3[2];
    assign req_off  = req_addr[OW-1:0];

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~req_we;
            3'b011:                 req_legal = (WIDTH == 64);
            3'b110:                 req_legal = (WIDTH == 64) && !req_we;
            default:                req_legal = 1'b0;
        endcase
    end

    always_comb begin
        req_misal = 1'b0;
        case (req_size)
            2'd1:    req_misal = req_addr[0];
            2'd2:    req_misal = |req_addr[1:0];
            2'd3:    req_misal = |req_addr[2:0];
            default: req_misal = 1'b0;
        endcase
    end

    always_comb begin
        size_mask = '1;
        case (req_size)
            2'd0:    size_mask = NB'(1);
            2'd1:    size_mask = NB'(3);
            2'd2:    size_mask = NB'(15);
            default: size_mask = '1;
        endcase
    end

    // Aligned requests never carry the mask past the top lane.
    assign req_be = size_mask << req_off;

    // Each lane takes the byte of the access that lands on it when the
    // access is repeated every (1 << size) bytes across the bus.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign req_wlane[8*gi +: 8] =
                (req_size == 2'd0) ? req_wdata[7:0] :
                (req_size == 2'd1) ? req_wdata[8*(gi%2) +: 8] :
                (req_size == 2'd2) ? req_wdata[8*(gi%4) +: 8] :
                                     req_wdata[8*(gi%8) +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-data lane select and extension (uses the captured request)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rd_shift;
    logic [WIDTH-1:0] rd_ext;
    logic             sbit;
    int               nbits;

    assign rd_shift = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        nbits  = WIDTH;
        sbit   = rd_shift[WIDTH-1];
        rd_ext = '0;
        case (size_q)
            2'd0: begin nbits = 8;  sbit = rd_shift[7];  end
            2'd1: begin nbits = 16; sbit = rd_shift[15]; end
            2'd2: begin nbits = 32; sbit = rd_shift[31]; end
            default: begin nbits = WIDTH; sbit = rd_shift[WIDTH-1]; end
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            rd_ext[i] = (i < nbits) ? rd_shift[i] : (sbit & ~uns_q);
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    logic tmo_hit;

    // The counter is 0 in the first REQ cycle, so the abort happens in the
    // (TIMEOUT+1)-th REQ/WAIT cycle after TIMEOUT full cycles of waiting.
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_VAL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        code_d     = code_q;
        rdata_d    = rdata_q;

        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_rd    = '0;
        err_valid  = 1'b0;
        err_code   = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                stall = req_valid & reset_n;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_uns;
                    off_d   = req_off;
                    rd_d    = req_rd;
                    addr_d  = {req_addr[DADDR-1:OW], {OW{1'b0}}};
                    be_d    = req_be;
                    wdata_d = req_wlane;
                    cnt_d   = '0;
                    if (!req_legal) begin
                        code_d  = CODE_ILLEGAL;
                        state_d = S_ERR;
                    end else if (req_misal) begin
                        code_d  = CODE_MISALIGN;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + TW'(1);
                if (tmo_hit) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_be    = be_q;
                    mem_wdata = wdata_q;
                    if (mem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + TW'(1);
                // A response arriving in the abort cycle is dropped.
                if (tmo_hit) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = S_ERR;
                end else if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : rd_ext;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_rd    = we_q ? 5'd0 : rd_q;
                state_d    = S_IDLE;
            end
            S_ERR: begin
                err_valid = 1'b1;
                err_code  = code_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            code_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            code_q  <= code_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// ---------------------------------------------------------------------------
// tb_lsu_handshake
//
// Directed bench for lsu_handshake (WIDTH=32, DADDR=16, TIMEOUT=4).
// Each transaction is described by its request and the cycle offsets at
// which memory grants and answers. A transaction-level model derives the
// expected per-cycle outputs from those offsets. A single negedge process
// compares the DUT against those expectations. Literal checks after key
// transactions pin the model against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lsu_handshake;

    localparam int W  = 32;
    localparam int NB = W / 8;
    localparam int DA = 16;
    localparam int TO = 4;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [DA-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic [4:0]    req_rd;
    logic          stall;
    logic          resp_valid;
    logic [W-1:0]  resp_rdata;
    logic [4:0]    resp_rd;
    logic          err_valid;
    logic [1:0]    err_code;
    logic          mem_req;
    logic          mem_we;
    logic [DA-1:0] mem_addr;
    logic [NB-1:0] mem_be;
    logic [W-1:0]  mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [W-1:0]  mem_rdata;

    lsu_handshake #(.WIDTH(W), .DADDR(DA), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mem_req_cycles = 0;
    bit chk_en  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle
    bit            e_all_zero;
    bit            e_stall, e_mem_req, e_resp_valid, e_err_valid;
    bit            e_we;
    logic [DA-1:0] e_addr;
    logic [NB-1:0] e_be;
    logic [W-1:0]  e_wdata;
    logic [4:0]    e_rd;
    bit            e_chk_rdata;
    logic [W-1:0]  e_rdata;
    logic [1:0]    e_code;

    // Last values the DUT presented while the matching valid was high
    logic [63:0] last_addr, last_be, last_wdata, last_rdata, last_rd, last_code;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_exp();
        e_all_zero = 0; e_stall = 0; e_mem_req = 0; e_resp_valid = 0; e_err_valid = 0;
        e_we = 0; e_addr = '0; e_be = '0; e_wdata = '0; e_rd = '0;
        e_chk_rdata = 0; e_rdata = '0; e_code = '0;
    endtask

    task automatic clear_last();
        last_addr = 'x; last_be = 'x; last_wdata = 'x;
        last_rdata = 'x; last_rd = 'x; last_code = 'x;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model ----------------
    function automatic bit m_legal(input bit we, input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1, 3'd2: return 1'b1;
            3'd4, 3'd5:       return !we;
            3'd3:             return (W == 64);
            3'd6:             return (W == 64) && !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic int m_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misal(input logic [2:0] f3, input logic [DA-1:0] addr);
        return (int'(addr) % m_bytes(f3)) != 0;
    endfunction

    function automatic logic [NB-1:0] m_be(input logic [2:0] f3, input logic [DA-1:0] addr);
        int mask;
        mask = ((1 << m_bytes(f3)) - 1) << (int'(addr) % NB);
        return NB'(mask);
    endfunction

    function automatic logic [W-1:0] m_wdata(input logic [2:0] f3, input logic [W-1:0] wd);
        longint unsigned v, res;
        int b;
        b = m_bytes(f3);
        v = longint'(wd) & ((64'd1 << (8 * b)) - 1);
        res = 0;
        for (int l = 0; l < NB; l += b) res |= v << (8 * l);
        return res[W-1:0];
    endfunction

    function automatic logic [W-1:0] m_rdata(input logic [2:0] f3, input logic [DA-1:0] addr,
                                             input logic [W-1:0] rd);
        longint unsigned v;
        int bits, lane;
        bits = 8 * m_bytes(f3);
        lane = int'(addr) % NB;
        v = (longint'(rd) >> (8 * lane)) & ((64'd1 << bits) - 1);
        if (!f3[2] && v[bits-1]) v = v - (64'd1 << bits);
        return v[W-1:0];
    endfunction

    // gd: REQ-cycle index at which mem_gnt is given (-1 = never)
    // rl: cycles after the grant cycle until mem_rvalid
    // poke: present an illegal request during the response cycle
    // noise: stray gnt/rvalid in cycles where they must be ignored
    // rst_k: REQ/WAIT cycle index at which reset is asserted (-1 = none)
    task automatic run(input string tag, input bit we, input logic [2:0] f3,
                       input logic [DA-1:0] addr, input logic [W-1:0] wd,
                       input logic [4:0] rd, input int gd, input int rl,
                       input logic [W-1:0] rdat, input bit poke, input bit noise,
                       input int rst_k);
        bit bad, granted, done, timed;
        int k, gk;
        logic [1:0] code;
        $display("[TB] txn %s we=%0d f3=%b addr=%h wdata=%h gnt@%0d rvalid+%0d",
                 tag, we, f3, addr, wd, gd, rl);
        clear_last();
        bad  = !m_legal(we, f3) || m_misal(f3, addr);
        code = !m_legal(we, f3) ? 2'b11 : 2'b01;

        step(); drive_idle(); clear_exp();
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd;
        e_stall = 1;

        if (bad) begin
            step(); drive_idle(); clear_exp();
            e_err_valid = 1; e_code = code;
        end else begin
            k = 0; gk = 0; granted = 0; done = 0; timed = 0;
            while (!done) begin
                step(); drive_idle(); clear_exp();
                if (rst_k == k) begin
                    reset_n = 1'b0;
                    e_all_zero = 1;
                    return;
                end
                req_valid = 1; e_stall = 1;
                if (TO != 0 && k == TO) begin
                    timed = 1; done = 1;
                    if (granted && k == gk + rl) begin
                        mem_rvalid = 1; mem_rdata = rdat;
                    end
                end else if (!granted) begin
                    e_mem_req = 1; e_we = we;
                    e_addr = addr - DA'(int'(addr) % NB);
                    e_be = m_be(f3, addr); e_wdata = m_wdata(f3, wd);
                    if (k == gd) begin
                        mem_gnt = 1; granted = 1; gk = k;
                    end else if (noise) begin
                        mem_rvalid = 1; mem_rdata = ~rdat;
                    end
                end else begin
                    if (noise) mem_gnt = 1;
                    if (k == gk + rl) begin
                        mem_rvalid = 1; mem_rdata = rdat; done = 1;
                    end
                end
                k++;
            end
            step(); drive_idle(); clear_exp();
            if (timed) begin
                e_err_valid = 1; e_code = 2'b10;
            end else begin
                e_resp_valid = 1; e_rd = we ? 5'd0 : rd;
                e_chk_rdata = !we; e_rdata = m_rdata(f3, addr, rdat);
            end
            if (poke) begin
                req_valid = 1; req_funct3 = 3'b111;
            end
            if (noise) begin
                mem_rvalid = 1; mem_gnt = 1;
            end
        end
        step(); drive_idle(); clear_exp();
        if (noise) begin
            mem_rvalid = 1; mem_rdata = rdat;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (e_all_zero) begin
                chk("rst_stall", stall, 0);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_be", mem_be, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_resp_rdata", resp_rdata, 0);
                chk("rst_resp_rd", resp_rd, 0);
                chk("rst_err_valid", err_valid, 0);
                chk("rst_err_code", err_code, 0);
            end else begin
                chk("stall", stall, e_stall);
                chk("mem_req", mem_req, e_mem_req);
                chk("resp_valid", resp_valid, e_resp_valid);
                chk("err_valid", err_valid, e_err_valid);
                if (e_mem_req && mem_req) begin
                    chk("mem_we", mem_we, e_we);
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_be", mem_be, e_be);
                    chk("mem_wdata", mem_wdata, e_wdata);
                end
                if (e_resp_valid && resp_valid) begin
                    chk("resp_rd", resp_rd, e_rd);
                    if (e_chk_rdata) chk("resp_rdata", resp_rdata, e_rdata);
                end
                if (e_err_valid && err_valid) chk("err_code", err_code, e_code);
            end
            if (mem_req) begin
                mem_req_cycles++;
                last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
            end
            if (resp_valid) begin
                last_rdata = resp_rdata; last_rd = resp_rd;
            end
            if (err_valid) last_code = err_code;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b1;
        drive_idle();
        req_we = 0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        clear_exp();
        clear_last();
        #2 reset_n = 1'b0;
        step();
        e_all_zero = 1;
        chk_en = 1;
        step();
        reset_n = 1'b1;
        clear_exp();
        step();

        run("LB", 0, 3'b000, 16'h0013, '0, 5'd5, 0, 1, 32'h80FF_7F00, 0, 0, -1);
        chk("lb_mem_addr", last_addr, 16'h0010);
        chk("lb_mem_be", last_be, 4'b1000);
        chk("lb_resp_rdata", last_rdata, 32'hFFFF_FF80);

        run("SH", 1, 3'b001, 16'h0022, 32'h0000_ABCD, 5'd7, 1, 2, '0, 1, 1, -1);
        chk("sh_mem_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_mem_be", last_be, 4'b1100);
        chk("sh_resp_rd", last_rd, 0);

        run("LW_mis", 0, 3'b010, 16'h0006, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        chk("lw_mis_code", last_code, 2'b01);
        run("F3_111", 0, 3'b111, 16'h0000, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        chk("f3_111_code", last_code, 2'b11);
        run("SBU", 1, 3'b100, 16'h0000, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        chk("sbu_code", last_code, 2'b11);

        mem_req_cycles = 0;
        run("LW_tmo", 0, 3'b010, 16'h0040, '0, 5'd9, -1, 1, 32'h1111_2222, 0, 1, -1);
        chk("tmo_mem_req_cycles", mem_req_cycles, 4);
        chk("tmo_code", last_code, 2'b10);
        run("LH_tmo_wait", 0, 3'b001, 16'h0010, '0, 5'd9, 0, 4, 32'h5555_6666, 0, 0, -1);
        chk("tmo_wait_code", last_code, 2'b10);

        run("LBU", 0, 3'b100, 16'h0011, '0, 5'd1, 2, 1, 32'h0000_8000, 0, 1, -1);
        chk("lbu_rdata", last_rdata, 32'h0000_0080);
        run("LH", 0, 3'b001, 16'h0012, '0, 5'd2, 0, 3, 32'h8001_0000, 0, 0, -1);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        run("SB", 1, 3'b000, 16'h0031, 32'h1234_5678, 5'd4, 0, 1, '0, 0, 0, -1);
        chk("sb_wdata", last_wdata, 32'h7878_7878);
        chk("sb_be", last_be, 4'b0010);
        run("SW", 1, 3'b010, 16'h0044, 32'hDEAD_BEEF, 5'd4, 1, 1, '0, 0, 0, -1);
        chk("sw_be", last_be, 4'b1111);
        run("LW", 0, 3'b010, 16'h0048, '0, 5'd31, 1, 2, 32'hCAFE_F00D, 1, 0, -1);
        chk("lw_rdata", last_rdata, 32'hCAFE_F00D);

        run("F3_111_mis", 0, 3'b111, 16'h0001, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        chk("prio_code", last_code, 2'b11);
        run("LH_mis", 0, 3'b001, 16'h0001, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        run("LD_w32", 0, 3'b011, 16'h0000, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        run("LWU_w32", 0, 3'b110, 16'h0000, '0, 5'd3, 0, 1, '0, 0, 0, -1);
        run("SHU", 1, 3'b101, 16'h0000, '0, 5'd3, 0, 1, '0, 0, 0, -1);

        // Reset while in WAIT; the stale response after release is ignored.
        run("LW_rst", 0, 3'b010, 16'h0020, '0, 5'd6, 0, 5, '0, 0, 0, 1);
        step(); drive_idle(); clear_exp(); e_all_zero = 1;
        step(); drive_idle(); clear_exp();
        reset_n = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        step(); drive_idle(); clear_exp();
        run("LHU", 0, 3'b101, 16'h0002, '0, 5'd8, 0, 1, 32'hF00D_0000, 0, 0, -1);
        chk("lhu_rdata", last_rdata, 32'h0000_F00D);

        step(); drive_idle(); clear_exp();
        step();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
